pipe_stage_reg: RTL and testbench

- Parametrised pipeline boundary register carrying an opaque decoded-instruction payload from one stage to the next.
- Generalises the fixed decode/execute boundary register:
  - configurable payload width, NOP encoding and stage position in the stall vector;
  - explicit valid bit and synchronous flush for exceptions and branch-mispredict;
  - delay-slot flag forwarding;
  - saturating bubble, hold and flush event counters for performance tracing.
- One instance sits between each pair of stages, e.g. IF/ID, ID/EX, EX/MEM.

---
 rtl/pipe_stage_reg.sv | 150 +++++++++++++++
 tb/tb_pipe_stage_reg.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// Pipeline boundary register between two stages.
// Carries an opaque payload plus valid and delay-slot flags. A stall vector
// selects advance, bubble or hold. A flush clears the boundary and takes
// priority over every stall combination. Saturating counters record bubble,
// hold and flush cycles for performance tracing.
module pipe_stage_reg #(
  parameter int unsigned       DATA_W    = 64,
  parameter logic [DATA_W-1:0] NOP_VALUE = {DATA_W{1'b0}},
  parameter int unsigned       STALL_W   = 6,
  parameter int unsigned       STAGE     = 2,
  parameter int unsigned       CNT_W     = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STALL_W-1:0] stall,
  input  logic               flush,
  input  logic               in_valid,
  input  logic [DATA_W-1:0]  in_payload,
  input  logic               in_delayslot,
  input  logic               next_delayslot_i,
  input  logic               cnt_clr,
  output logic               out_valid,
  output logic [DATA_W-1:0]  out_payload,
  output logic               out_delayslot,
  output logic               is_in_delayslot_o,
  output logic [CNT_W-1:0]   bubble_cnt,
  output logic [CNT_W-1:0]   hold_cnt,
  output logic [CNT_W-1:0]   flush_cnt
);

  typedef enum logic [1:0] {
    ACT_ADVANCE,
    ACT_BUBBLE,
    ACT_HOLD,
    ACT_FLUSH
  } action_e;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // Count up by one and stick at the all-ones value instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_ONE;
  endfunction

  logic              up;
  logic              dn;
  logic              stall_unused;
  action_e           action;

  logic [DATA_W-1:0] payload_q, payload_d;
  logic              valid_q, valid_d;
  logic              ds_q, ds_d;
  logic              isds_q, isds_d;
  logic [CNT_W-1:0]  bubble_q, bubble_d;
  logic [CNT_W-1:0]  hold_q, hold_d;
  logic [CNT_W-1:0]  flush_q, flush_d;

  // Only the upstream and downstream stop flags matter here.
  assign up           = stall[STAGE];
  assign dn           = stall[STAGE+1];
  assign stall_unused = ^stall;

  // Pick this edge's action. Flush wins, then bubble, then advance, then hold.
  // An advance happens whenever upstream runs, even if downstream is stopped.
  always_comb begin
    action = ACT_HOLD;
    if (flush)          action = ACT_FLUSH;
    else if (up && !dn) action = ACT_BUBBLE;
    else if (!up)       action = ACT_ADVANCE;
  end

  // Next payload and flags for the chosen action.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can leave one unassigned and infer a latch.
    payload_d = payload_q;
    valid_d   = valid_q;
    ds_d      = ds_q;
    isds_d    = isds_q;
    case (action)
      ACT_FLUSH: begin
        payload_d = NOP_VALUE;
        valid_d   = 1'b0;
        ds_d      = 1'b0;
        isds_d    = 1'b0;
      end
      ACT_BUBBLE: begin
        payload_d = NOP_VALUE;
        valid_d   = 1'b0;
        ds_d      = 1'b0;
      end
      ACT_ADVANCE: begin
        payload_d = in_payload;
        valid_d   = in_valid;
        ds_d      = in_delayslot;
        isds_d    = next_delayslot_i;
      end
      default: ;
    endcase
  end

  // Next counter values. A clear overrides any increment in the same cycle.
  always_comb begin
    bubble_d = bubble_q;
    hold_d   = hold_q;
    flush_d  = flush_q;
    if (cnt_clr) begin
      bubble_d = '0;
      hold_d   = '0;
      flush_d  = '0;
    end else begin
      case (action)
        ACT_BUBBLE: bubble_d = sat_inc(bubble_q);
        ACT_HOLD:   hold_d   = sat_inc(hold_q);
        ACT_FLUSH:  flush_d  = sat_inc(flush_q);
        default: ;
      endcase
    end
  end

  // State registers. Reset is asynchronous and clears everything at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      payload_q <= NOP_VALUE;
      valid_q   <= 1'b0;
      ds_q      <= 1'b0;
      isds_q    <= 1'b0;
      bubble_q  <= '0;
      hold_q    <= '0;
      flush_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values, so block order cannot matter.
      payload_q <= payload_d;
      valid_q   <= valid_d;
      ds_q      <= ds_d;
      isds_q    <= isds_d;
      bubble_q  <= bubble_d;
      hold_q    <= hold_d;
      flush_q   <= flush_d;
    end
  end

  assign out_payload       = payload_q;
  assign out_valid         = valid_q;
  assign out_delayslot     = ds_q;
  assign is_in_delayslot_o = isds_q;
  assign bubble_cnt        = bubble_q;
  assign hold_cnt          = hold_q;
  assign flush_cnt         = flush_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg.
// Two instances share one stimulus: one with default 8-bit counters and one
// with 2-bit counters so that saturation can be reached. A behavioural model
// pushes the expected outputs into a scoreboard queue as each cycle is
// driven. Each test pops one entry after the edge and compares the DUT
// outputs against it.
module tb_pipe_stage_reg;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall = '0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic [63:0] in_payload = '0;
  logic        in_delayslot = 1'b0;
  logic        next_delayslot_i = 1'b0;
  logic        cnt_clr = 1'b0;

  logic        out_valid, out_delayslot, is_in_delayslot_o;
  logic [63:0] out_payload;
  logic [7:0]  bubble_cnt, hold_cnt, flush_cnt;

  logic        s_out_valid, s_out_delayslot, s_is_in_delayslot_o;
  logic [63:0] s_out_payload;
  logic [1:0]  s_bubble_cnt, s_hold_cnt, s_flush_cnt;

  always #5 clk = ~clk;

  pipe_stage_reg dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .in_valid(in_valid), .in_payload(in_payload), .in_delayslot(in_delayslot),
    .next_delayslot_i(next_delayslot_i), .cnt_clr(cnt_clr),
    .out_valid(out_valid), .out_payload(out_payload), .out_delayslot(out_delayslot),
    .is_in_delayslot_o(is_in_delayslot_o), .bubble_cnt(bubble_cnt),
    .hold_cnt(hold_cnt), .flush_cnt(flush_cnt)
  );

  pipe_stage_reg #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .in_valid(in_valid), .in_payload(in_payload), .in_delayslot(in_delayslot),
    .next_delayslot_i(next_delayslot_i), .cnt_clr(cnt_clr),
    .out_valid(s_out_valid), .out_payload(s_out_payload), .out_delayslot(s_out_delayslot),
    .is_in_delayslot_o(s_is_in_delayslot_o), .bubble_cnt(s_bubble_cnt),
    .hold_cnt(s_hold_cnt), .flush_cnt(s_flush_cnt)
  );

  typedef struct {
    logic [63:0] payload;
    logic        valid;
    logic        ds;
    logic        isds;
    logic [7:0]  bub, hold, fl;
    logic [1:0]  bub2, hold2, fl2;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   n_checks = 0;
  int   n_fail   = 0;

  // Model state
  logic [63:0] m_payload;
  logic        m_valid, m_ds, m_isds;
  int          m_bub, m_hold, m_fl, m_bub2, m_hold2, m_fl2;

  function automatic int sat(input int v, input int mx);
    return (v >= mx) ? mx : v + 1;
  endfunction

  task automatic model_reset();
    m_payload = '0; m_valid = 0; m_ds = 0; m_isds = 0;
    m_bub = 0; m_hold = 0; m_fl = 0; m_bub2 = 0; m_hold2 = 0; m_fl2 = 0;
  endtask

  task automatic pop_exp();
    if (sb.size() == 0) begin
      n_checks++; n_fail++;
      $display("FAIL scoreboard_empty: no expected entry available");
    end else begin
      e = sb.pop_front();
    end
  endtask

  // Apply one cycle of inputs, predict the post-edge outputs, advance the clock.
  task automatic drive(input logic [5:0] st, input logic fl, input logic v,
                       input logic [63:0] p, input logic ds, input logic nds,
                       input logic clr);
    exp_t x;
    logic u, d;
    stall = st; flush = fl; in_valid = v; in_payload = p;
    in_delayslot = ds; next_delayslot_i = nds; cnt_clr = clr;
    if (!rst) begin
      model_reset();
    end else begin
      u = st[2];
      d = st[3];
      if (fl) begin
        m_payload = '0; m_valid = 0; m_ds = 0; m_isds = 0;
        m_fl = sat(m_fl, 255); m_fl2 = sat(m_fl2, 3);
      end else if (u && !d) begin
        m_payload = '0; m_valid = 0; m_ds = 0;
        m_bub = sat(m_bub, 255); m_bub2 = sat(m_bub2, 3);
      end else if (!u) begin
        m_payload = p; m_valid = v; m_ds = ds; m_isds = nds;
      end else begin
        m_hold = sat(m_hold, 255); m_hold2 = sat(m_hold2, 3);
      end
      if (clr) begin
        m_bub = 0; m_hold = 0; m_fl = 0; m_bub2 = 0; m_hold2 = 0; m_fl2 = 0;
      end
    end
    x.payload = m_payload; x.valid = m_valid; x.ds = m_ds; x.isds = m_isds;
    x.bub  = 8'(m_bub);  x.hold  = 8'(m_hold);  x.fl  = 8'(m_fl);
    x.bub2 = 2'(m_bub2); x.hold2 = 2'(m_hold2); x.fl2 = 2'(m_fl2);
    sb.push_back(x);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(6'b000000, 1'b0, 1'b1, 64'hDEAD_BEEF, 1'b1, 1'b1, 1'b0);
      pop_exp();
      n_checks++;
      if (out_payload !== e.payload || out_valid !== e.valid) begin
        n_fail++;
        $display("FAIL reset_out: got payload=%h valid=%b, want payload=%h valid=%b",
                 out_payload, out_valid, e.payload, e.valid);
      end
      n_checks++;
      if ({bubble_cnt, hold_cnt, flush_cnt} !== {e.bub, e.hold, e.fl}) begin
        n_fail++;
        $display("FAIL reset_cnt: got %h, want %h", {bubble_cnt, hold_cnt, flush_cnt},
                 {e.bub, e.hold, e.fl});
      end
    end
    rst = 1'b1;
  endtask

  task automatic test_advance();
    drive(6'b000000, 1'b0, 1'b1, 64'h1234, 1'b1, 1'b1, 1'b0);
    pop_exp();
    n_checks++;
    if (out_payload !== e.payload) begin
      n_fail++;
      $display("FAIL advance_payload: got %h, want %h", out_payload, e.payload);
    end
    n_checks++;
    if ({out_valid, out_delayslot, is_in_delayslot_o} !== {e.valid, e.ds, e.isds}) begin
      n_fail++;
      $display("FAIL advance_flags: got %b, want %b",
               {out_valid, out_delayslot, is_in_delayslot_o}, {e.valid, e.ds, e.isds});
    end
  endtask

  task automatic test_bubble();
    for (int i = 0; i < 2; i++) begin
      drive(6'b000111, 1'b0, 1'b1, 64'h5555, 1'b1, 1'b0, 1'b0);
      pop_exp();
      n_checks++;
      if ({out_payload, out_valid, out_delayslot, is_in_delayslot_o} !==
          {e.payload, e.valid, e.ds, e.isds}) begin
        n_fail++;
        $display("FAIL bubble_out: got %h/%b%b%b, want %h/%b%b%b", out_payload, out_valid,
                 out_delayslot, is_in_delayslot_o, e.payload, e.valid, e.ds, e.isds);
      end
      n_checks++;
      if (bubble_cnt !== e.bub || s_bubble_cnt !== e.bub2) begin
        n_fail++;
        $display("FAIL bubble_cnt: got %0d/%0d, want %0d/%0d", bubble_cnt, s_bubble_cnt,
                 e.bub, e.bub2);
      end
    end
  endtask

  task automatic test_hold();
    drive(6'b000000, 1'b0, 1'b1, 64'hABCD, 1'b0, 1'b0, 1'b0);
    pop_exp();
    for (int i = 0; i < 3; i++) begin
      drive(6'b001111, 1'b0, 1'b1, 64'h9000 + 64'(i), 1'b1, 1'b1, 1'b0);
      pop_exp();
      n_checks++;
      if (out_payload !== e.payload || out_valid !== e.valid) begin
        n_fail++;
        $display("FAIL hold_payload: got %h/%b, want %h/%b", out_payload, out_valid,
                 e.payload, e.valid);
      end
      n_checks++;
      if (hold_cnt !== e.hold || s_hold_cnt !== e.hold2) begin
        n_fail++;
        $display("FAIL hold_cnt: got %0d/%0d, want %0d/%0d", hold_cnt, s_hold_cnt,
                 e.hold, e.hold2);
      end
    end
    drive(6'b000000, 1'b0, 1'b1, 64'h7777, 1'b0, 1'b1, 1'b0);
    pop_exp();
    n_checks++;
    if (out_payload !== e.payload || is_in_delayslot_o !== e.isds) begin
      n_fail++;
      $display("FAIL hold_release: got %h/%b, want %h/%b", out_payload, is_in_delayslot_o,
               e.payload, e.isds);
    end
  endtask

  task automatic test_flush();
    drive(6'b001111, 1'b1, 1'b1, 64'h4321, 1'b1, 1'b1, 1'b0);
    pop_exp();
    n_checks++;
    if ({out_payload, out_valid, out_delayslot, is_in_delayslot_o} !==
        {e.payload, e.valid, e.ds, e.isds}) begin
      n_fail++;
      $display("FAIL flush_out: got %h/%b%b%b, want %h/%b%b%b", out_payload, out_valid,
               out_delayslot, is_in_delayslot_o, e.payload, e.valid, e.ds, e.isds);
    end
    n_checks++;
    if (flush_cnt !== e.fl || hold_cnt !== e.hold) begin
      n_fail++;
      $display("FAIL flush_cnt: got flush=%0d hold=%0d, want flush=%0d hold=%0d",
               flush_cnt, hold_cnt, e.fl, e.hold);
    end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 5; i++) begin
      drive(6'b000111, 1'b0, 1'b0, 64'h0, 1'b0, 1'b0, 1'b0);
      pop_exp();
      n_checks++;
      if (s_bubble_cnt !== e.bub2 || bubble_cnt !== e.bub) begin
        n_fail++;
        $display("FAIL sat_bubble: got %0d/%0d, want %0d/%0d", s_bubble_cnt, bubble_cnt,
                 e.bub2, e.bub);
      end
    end
    drive(6'b000111, 1'b0, 1'b0, 64'h0, 1'b0, 1'b0, 1'b1);
    pop_exp();
    n_checks++;
    if ({s_bubble_cnt, s_hold_cnt, s_flush_cnt} !== {e.bub2, e.hold2, e.fl2} ||
        {bubble_cnt, hold_cnt, flush_cnt} !== {e.bub, e.hold, e.fl}) begin
      n_fail++;
      $display("FAIL clr_override: got %h %h, want %h %h",
               {s_bubble_cnt, s_hold_cnt, s_flush_cnt}, {bubble_cnt, hold_cnt, flush_cnt},
               {e.bub2, e.hold2, e.fl2}, {e.bub, e.hold, e.fl});
    end
    drive(6'b000111, 1'b0, 1'b0, 64'h0, 1'b0, 1'b0, 1'b0);
    pop_exp();
    n_checks++;
    if (s_bubble_cnt !== e.bub2 || bubble_cnt !== e.bub) begin
      n_fail++;
      $display("FAIL after_clr: got %0d/%0d, want %0d/%0d", s_bubble_cnt, bubble_cnt,
               e.bub2, e.bub);
    end
  endtask

  // Reset asserted between edges must clear outputs immediately.
  task automatic test_async_reset();
    drive(6'b001111, 1'b0, 1'b1, 64'h1, 1'b0, 1'b0, 1'b0);
    pop_exp();
    drive(6'b000000, 1'b0, 1'b1, 64'hCAFE_F00D, 1'b1, 1'b1, 1'b0);
    pop_exp();
    #2 rst = 1'b0;
    #1;
    model_reset();
    n_checks++;
    if ({out_payload, out_valid, out_delayslot, is_in_delayslot_o} !== {64'h0, 3'b000} ||
        {bubble_cnt, hold_cnt, flush_cnt} !== 24'h0 ||
        {s_out_payload, s_out_valid, s_bubble_cnt, s_hold_cnt} !== {64'h0, 1'b0, 4'h0}) begin
      n_fail++;
      $display("FAIL async_reset: got %h/%b%b%b cnt=%h, want all zero", out_payload,
               out_valid, out_delayslot, is_in_delayslot_o, {bubble_cnt, hold_cnt, flush_cnt});
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  // Random mix of legal stall patterns, the odd up=0/dn=1 pattern, flushes and clears.
  task automatic test_back_to_back();
    logic [5:0] st;
    int k;
    for (int i = 0; i < 80; i++) begin
      k = int'($urandom_range(0, 7));
      st = (k == 7) ? 6'b001000 : 6'((1 << k) - 1);
      drive(st, ($urandom_range(0, 7) == 0), 1'($urandom), {$urandom, $urandom},
            1'($urandom), 1'($urandom), ($urandom_range(0, 15) == 0));
      pop_exp();
      n_checks++;
      if ({out_payload, out_valid, out_delayslot, is_in_delayslot_o,
           bubble_cnt, hold_cnt, flush_cnt} !==
          {e.payload, e.valid, e.ds, e.isds, e.bub, e.hold, e.fl}) begin
        n_fail++;
        $display("FAIL b2b_main cycle %0d stall=%b: got %h/%b%b%b %h, want %h/%b%b%b %h", i, st,
                 out_payload, out_valid, out_delayslot, is_in_delayslot_o,
                 {bubble_cnt, hold_cnt, flush_cnt}, e.payload, e.valid, e.ds, e.isds,
                 {e.bub, e.hold, e.fl});
      end
      n_checks++;
      if ({s_out_payload, s_out_valid, s_out_delayslot, s_is_in_delayslot_o,
           s_bubble_cnt, s_hold_cnt, s_flush_cnt} !==
          {e.payload, e.valid, e.ds, e.isds, e.bub2, e.hold2, e.fl2}) begin
        n_fail++;
        $display("FAIL b2b_sat cycle %0d: got cnt=%h, want cnt=%h", i,
                 {s_bubble_cnt, s_hold_cnt, s_flush_cnt}, {e.bub2, e.hold2, e.fl2});
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_advance();
    test_bubble();
    test_hold();
    test_flush();
    test_saturation();
    test_async_reset();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
